// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared types and sizes for the 4-requester round-robin mux arbiter.
// Latency: none (declarations only).
// Backpressure: not applicable.
package mux4_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;
  localparam int CNT_W   = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // One-hot grant vector for a requester index.
  function automatic logic [NUM_REQ-1:0] idx_onehot(input logic [SEL_W-1:0] idx);
    return NUM_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_pick.sv
// Rotating-priority picker: first set bit of req scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
// Latency: purely combinational.
// Backpressure: not applicable; found=0 when req is all zero.
module rr_pick4
  import mux4_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic [SEL_W-1:0]   idx,
  output logic               found
);

  logic [SEL_W-1:0] cand;

  // Scan from the farthest offset down so the nearest set bit to ptr wins.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = ptr + SEL_W'(k);
      if (req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 data mux, with bounded grant tenure; MUX4_ARB_LOCK_EN adds a lock input.
// Latency: grant registered 1 cycle after req; out_valid/out_data combinational from the registered select.
// Backpressure: out_ready low stalls the owner with data held; tenure counts only accepted transfers.
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int DW       = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_REQ-1:0]  req,
  input  logic [DW-1:0]       in0,
  input  logic [DW-1:0]       in1,
  input  logic [DW-1:0]       in2,
  input  logic [DW-1:0]       in3,
`ifdef MUX4_ARB_LOCK_EN
  input  logic                lock,
`endif
  input  logic                out_ready,
  output logic                out_valid,
  output logic [DW-1:0]       out_data,
  output logic [NUM_REQ-1:0]  gnt,
  output logic                s0,
  output logic                s1,
  output logic                busy
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD - 1);

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   owner_q, owner_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [SEL_W-1:0]   sel_q, sel_d;

  logic [NUM_REQ-1:0] pick_req;
  logic [SEL_W-1:0]   pick_ptr;
  logic [SEL_W-1:0]   pick_idx;
  logic               pick_found;

  logic               lock_on;
  logic               xfer;
  logic               others_wait;
  logic               rel_drop;
  logic               rel_tenure;

`ifdef MUX4_ARB_LOCK_EN
  assign lock_on = lock;
`else
  assign lock_on = 1'b0;
`endif

  assign out_valid   = (state_q == GRANT) && req[owner_q];
  assign xfer        = out_valid && out_ready;
  assign others_wait = |(req & ~gnt_q);
  assign rel_drop    = !req[owner_q];
  assign rel_tenure  = xfer && (cnt_q == CNT_MAX) && others_wait && !lock_on;

  // One picker serves both the idle pick and the handover pick on release.
  always_comb begin
    pick_req = req;
    pick_ptr = ptr_q;
    if (state_q == GRANT) begin
      pick_req = req & ~gnt_q;
      pick_ptr = owner_q + SEL_W'(1);
    end
  end

  rr_pick4 u_pick (
    .req   (pick_req),
    .ptr   (pick_ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // Next-state: grant on request, count transfers, hand over or go idle on release.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = GRANT;
          owner_d = pick_idx;
          gnt_d   = idx_onehot(pick_idx);
          sel_d   = pick_idx;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (xfer && (cnt_q != CNT_MAX)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (rel_drop || rel_tenure) begin
          ptr_d = owner_q + SEL_W'(1);
          if (pick_found) begin
            owner_d = pick_idx;
            gnt_d   = idx_onehot(pick_idx);
            sel_d   = pick_idx;
            cnt_d   = '0;
          end else begin
            // Select keeps its last value so out_data does not glitch when idle.
            state_d = IDLE;
            gnt_d   = '0;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
    end
  end

  // Data path: 4:1 mux driven by the registered select.
  always_comb begin
    out_data = in0;
    case (sel_q)
      2'd0:    out_data = in0;
      2'd1:    out_data = in1;
      2'd2:    out_data = in2;
      default: out_data = in3;
    endcase
  end

  assign gnt  = gnt_q;
  assign s1   = sel_q[1];
  assign s0   = sel_q[0];
  assign busy = (state_q == GRANT);

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: directed scenarios plus random traffic against a reference model.
// Latency: model tracks the registered grant, compared half a cycle after inputs change.
// Backpressure: random out_ready exercises stalls; data check covers every cycle.
module tb_mux4_rr_arbiter;

  localparam int DW = 8;
  localparam int MH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    req;
  logic [DW-1:0] din [4];
  logic          out_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [3:0]    gnt;
  logic          s0, s1, busy;
  logic          lock;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int m_busy, m_owner, m_ptr, m_cnt, m_sel;

  always #5 clk = ~clk;

  mux4_rr_arbiter #(.DW(DW), .MAX_HOLD(MH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .in0       (din[0]),
    .in1       (din[1]),
    .in2       (din[2]),
    .in3       (din[3]),
`ifdef MUX4_ARB_LOCK_EN
    .lock      (lock),
`endif
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .gnt       (gnt),
    .s0        (s0),
    .s1        (s1),
    .busy      (busy)
  );

  function automatic int pick(input logic [3:0] mask, input int start);
    for (int k = 0; k < 4; k++) begin
      if (mask[(start + k) % 4]) return (start + k) % 4;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_ptr = 0; m_cnt = 0; m_sel = 0;
  endtask

  // Advance the model by one clock using the inputs present at the edge.
  task automatic model_step();
    logic [3:0] me;
    int w;
    bit xf, rel;
    if (rst) begin
      model_reset();
    end else if (m_busy == 0) begin
      if (req != 4'b0) begin
        w = pick(req, m_ptr);
        m_busy = 1; m_owner = w; m_sel = w; m_cnt = 0;
      end
    end else begin
      me  = 4'b0001 << m_owner;
      xf  = req[m_owner] && out_ready;
      rel = !req[m_owner] ||
            (xf && (m_cnt == MH - 1) && ((req & ~me) != 4'b0) && !lock);
      if (xf && m_cnt < MH - 1) m_cnt++;
      if (rel) begin
        m_ptr = (m_owner + 1) % 4;
        w = pick(req & ~me, m_ptr);
        if (w >= 0) begin
          m_owner = w; m_sel = w; m_cnt = 0;
        end else begin
          m_busy = 0;
        end
      end
    end
  endtask

  task automatic check_model();
    logic [3:0] eg;
    eg = (m_busy != 0) ? (4'b0001 << m_owner) : 4'b0;
    chk("m_gnt",   32'(gnt),       32'(eg));
    chk("m_sel",   32'({s1, s0}),  32'(m_sel));
    chk("m_busy",  32'(busy),      32'(m_busy));
    chk("m_valid", 32'(out_valid), 32'((m_busy != 0) && req[m_owner]));
    chk("m_data",  32'(out_data),  32'(din[m_sel]));
  endtask

  // Apply inputs at the falling edge, then compare shortly after.
  task automatic drive(input logic [3:0] r, input logic rd, input bit rnd,
                       input logic rs, input logic lk);
    @(negedge clk);
    rst       = rs;
    req       = r;
    out_ready = rd;
    lock      = lk;
    for (int i = 0; i < 4; i++) din[i] = rnd ? DW'($urandom) : DW'(8'hA0 + i);
    #1;
    check_model();
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
  endtask

  initial begin
    logic [3:0] rq;
    rst = 1'b1; req = 4'b1111; out_ready = 1'b1; lock = 1'b0;
    for (int i = 0; i < 4; i++) din[i] = DW'(8'hA0 + i);
    repeat (2) @(posedge clk);
    model_reset();

    // Reset held with all requests pending
    drive(4'b1111, 1'b1, 0, 1'b1, 1'b0);
    chk("rst_gnt",   32'(gnt), 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_busy",  32'(busy), 32'h0);
    chk("rst_data",  32'(out_data), 32'hA0);
    tick();
    drive(4'b1111, 1'b1, 0, 1'b0, 1'b0);
    tick();

    // Rotation: four transfers per requester, no bubbles
    for (int k = 0; k < 20; k++) begin
      drive(4'b1111, 1'b1, 0, 1'b0, 1'b0);
      if (k == 0) chk("first_gnt", 32'(gnt), 32'h1);
      chk("rot_valid", 32'(out_valid), 32'h1);
      chk("rot_data",  32'(out_data), 32'(8'hA0 + (k / 4) % 4));
      tick();
    end

    // Sole requester keeps the grant indefinitely
    drive(4'b0100, 1'b1, 0, 1'b0, 1'b0);
    tick();
    for (int k = 0; k < 20; k++) begin
      drive(4'b0100, 1'b1, 0, 1'b0, 1'b0);
      chk("sole_gnt",  32'(gnt), 32'h4);
      chk("sole_sel",  32'({s1, s0}), 32'h2);
      chk("sole_data", 32'(out_valid ? out_data : 8'h00), 32'hA2);
      tick();
    end

    // Backpressure on owner 1: stalls do not consume tenure
    drive(4'b0010, 1'b1, 0, 1'b0, 1'b0);
    tick();
    for (int k = 0; k < 5; k++) begin
      drive(4'b0110, 1'b0, 0, 1'b0, 1'b0);
      chk("bp_valid", 32'(out_valid), 32'h1);
      chk("bp_data",  32'(out_data), 32'hA1);
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      drive(4'b0110, 1'b1, 0, 1'b0, 1'b0);
      chk("bp_hold_gnt", 32'(gnt), 32'h2);
      tick();
    end
    drive(4'b0110, 1'b1, 0, 1'b0, 1'b0);
    chk("bp_rot_gnt", 32'(gnt), 32'h4);
    tick();

    // Drop and wrap: owner 3 drops while req[0] waits
    drive(4'b1001, 1'b0, 0, 1'b0, 1'b0);
    tick();
    drive(4'b1001, 1'b0, 0, 1'b0, 1'b0);
    chk("wrap_own3", 32'(gnt), 32'h8);
    tick();
    drive(4'b0001, 1'b0, 0, 1'b0, 1'b0);
    tick();
    drive(4'b0001, 1'b0, 0, 1'b0, 1'b0);
    chk("wrap_gnt0", 32'(gnt), 32'h1);
    tick();
    drive(4'b1000, 1'b0, 0, 1'b0, 1'b0);
    tick();
    drive(4'b0000, 1'b0, 0, 1'b0, 1'b0);
    chk("idle_pre_gnt", 32'(gnt), 32'h8);
    tick();
    drive(4'b0000, 1'b0, 0, 1'b0, 1'b0);
    chk("idle_gnt",  32'(gnt), 32'h0);
    chk("idle_sel",  32'({s1, s0}), 32'h3);
    chk("idle_busy", 32'(busy), 32'h0);
    tick();
    drive(4'b1111, 1'b1, 0, 1'b0, 1'b0);
    tick();
    drive(4'b1111, 1'b1, 0, 1'b0, 1'b0);
    chk("ptr_wrap_gnt", 32'(gnt), 32'h1);
    tick();

`ifdef MUX4_ARB_LOCK_EN
    // Lock suppresses tenure release while contention exists
    for (int k = 0; k < 10; k++) begin
      drive(4'b0011, 1'b1, 0, 1'b0, 1'b1);
      chk("lock_gnt",  32'(gnt), 32'h1);
      chk("lock_data", 32'(out_data), 32'hA0);
      tick();
    end
    drive(4'b0011, 1'b1, 0, 1'b0, 1'b0);
    chk("unlock_last", 32'(gnt), 32'h1);
    tick();
    drive(4'b0011, 1'b1, 0, 1'b0, 1'b0);
    chk("unlock_gnt", 32'(gnt), 32'h2);
    tick();
`endif

    // Random traffic against the model
    rq = 4'b0000;
    for (int k = 0; k < 600; k++) begin
      for (int b = 0; b < 4; b++) if ($urandom_range(5) == 0) rq[b] = ~rq[b];
      drive(rq, ($urandom_range(3) != 0), 1, ($urandom_range(63) == 0),
`ifdef MUX4_ARB_LOCK_EN
            ($urandom_range(2) == 0)
`else
            1'b0
`endif
      );
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
